// File: rtl/output_drain_ctrl_pkg.sv
// Shared definitions for the AES output drain path.
// FIFO entry layout, beat geometry and the drain FSM states.
package output_drain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } drain_state_t;

    localparam int BLK_W   = 128;
    localparam int TAG_W   = 2;
    localparam int TAG_LSB = BLK_W;
    localparam int TAG_MSB = BLK_W + TAG_W - 1;
    localparam int NBEATS  = BLK_W / 32;

    function automatic int beats_of(input int width, input int out_w);
        return (width - TAG_W) / out_w;
    endfunction

endpackage

// File: rtl/output_drain_ctrl_if.sv
// FIFO read side and beat stream of the output drain.
// master = drain controller, slave = FIFO plus downstream sink.
interface output_drain_ctrl_if #(
    parameter int WIDTH = 130,
    parameter int OUT_W = 32
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_tag;
    logic             out_last;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output out_tag,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  out_tag,
        input  out_last
    );

endinterface

// File: rtl/output_drain_ctrl.sv
// Pops tagged AES blocks from the output FIFO and streams
// them downstream as OUT_W beats, least-significant first.
module output_drain_ctrl
    import output_drain_ctrl_pkg::*;
#(
    parameter int WIDTH = 130,
    parameter int OUT_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    output_drain_ctrl_if.master dif,
    output logic                busy,
    output logic [15:0]         entry_cnt
);

    localparam int BW = WIDTH - TAG_W;
    localparam int NB = beats_of(WIDTH, OUT_W);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

    drain_state_t     state;
    logic [BW-1:0]    shreg;
    logic [TAG_W-1:0] tag_q;
    logic [CW-1:0]    beat_cnt;
    logic             valid_q;
    logic             last_q;
    logic             rd_go;
    logic             hs;

    // Strobe is combinational so the word is on fifo_dout in FETCH
    assign rd_go = rstn && enable && !dif.fifo_empty
                   && (state == IDLE);
    assign hs    = valid_q && dif.out_ready;

    assign dif.fifo_rd_en = rd_go;
    assign dif.out_valid  = valid_q;
    assign dif.out_data   = shreg[OUT_W-1:0];
    assign dif.out_tag    = tag_q;
    assign dif.out_last   = last_q;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            shreg     <= '0;
            tag_q     <= '0;
            beat_cnt  <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            entry_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_go) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    shreg    <= dif.fifo_dout[BW-1:0];
                    tag_q    <= dif.fifo_dout[WIDTH-1 -: TAG_W];
                    beat_cnt <= '0;
                    valid_q  <= 1'b1;
                    last_q   <= (NB == 1);
                    state    <= SEND;
                end
                SEND: begin
                    if (hs && last_q) begin
                        valid_q   <= 1'b0;
                        last_q    <= 1'b0;
                        beat_cnt  <= '0;
                        entry_cnt <= entry_cnt + 16'd1;
                        state     <= IDLE;
                    end else if (hs) begin
                        // Next beat slides down into the low lane
                        shreg    <= shreg >> OUT_W;
                        beat_cnt <= beat_cnt + 1'b1;
                        last_q   <= (beat_cnt + 1'b1 == LAST_BEAT);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_rd_only_idle: assert property (
        @(posedge clk) disable iff (!rstn)
        dif.fifo_rd_en |-> (state == IDLE) && !dif.fifo_empty
    );

    a_hold_on_stall: assert property (
        @(posedge clk) disable iff (!rstn)
        valid_q && !dif.out_ready |=>
            valid_q && $stable(dif.out_data) && $stable(tag_q)
            && $stable(last_q)
    );

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Bench for output_drain_ctrl: vector table, hand sequences
// and a randomized run against a queue-based beat model.
`timescale 1ns/1ps
module tb_output_drain_ctrl;
    import output_drain_ctrl_pkg::*;

    localparam int WIDTH = 130;
    localparam int OUT_W = 32;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  tag;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [1:0]        tag;
        logic [127:0]      blk;
        logic [3:0][31:0]  beats;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [15:0] entry_cnt;

    output_drain_ctrl_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dif ();

    output_drain_ctrl #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .dif       (dif),
        .busy      (busy),
        .entry_cnt (entry_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: read data appears the cycle after the strobe
    logic [WIDTH-1:0] mem [0:255];
    int unsigned      wr_ptr = 0;
    int unsigned      rd_ptr = 0;
    logic [WIDTH-1:0] dout_q = '0;

    assign dif.fifo_empty = (wr_ptr == rd_ptr);
    assign dif.fifo_dout  = dout_q;

    always @(posedge clk) begin
        if (dif.fifo_rd_en) begin
            dout_q <= mem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int    n_cmp = 0;
    int    n_fail = 0;
    int    rd_seen = 0;
    int    ecnt = 0;
    beat_t got[$];
    int    got_cyc[$];
    beat_t exp[$];
    logic  stall_prev = 1'b0;
    beat_t held = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    function automatic beat_t cur();
        beat_t b;
        b.data = dif.out_data;
        b.tag  = dif.out_tag;
        b.last = dif.out_last;
        return b;
    endfunction

    // Model: an entry becomes NBEATS beats, low word first
    task automatic push(input logic [1:0] tag, input logic [127:0] blk);
        beat_t b;
        mem[wr_ptr % 256] = {tag, blk};
        wr_ptr++;
        for (int i = 0; i < NBEATS; i++) begin
            b.data = blk[i*32 +: 32];
            b.tag  = tag;
            b.last = (i == NBEATS - 1);
            exp.push_back(b);
        end
    endtask

    task automatic observe();
        #1;
        if (dif.fifo_rd_en === 1'b1) begin
            rd_seen++;
            chk("rd_gate", 64'({enable, dif.fifo_empty, busy}),
                64'(3'b100));
        end
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", 64'({dif.out_valid, cur()}),
                    64'({1'b1, held}));
            if (dif.out_valid && dif.out_ready) begin
                got.push_back(cur());
                got_cyc.push_back(cyc);
            end
            stall_prev = dif.out_valid && !dif.out_ready;
            held = cur();
        end
    endtask

    task automatic step();
        observe();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((got.size() < exp.size() || busy || !dif.fifo_empty)
               && n < budget) begin
            step();
            n++;
        end
        chk("drain_idle", 64'(busy), 64'(0));
    endtask

    task automatic score(input string nm);
        chk({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk(nm, 64'(got[i]), 64'(exp[i]));
        got.delete();
        got_cyc.delete();
        exp.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[3];
        int   r0;
        int   n;

        vecs[0] = '{tag: 2'b01,
                    blk: 128'h0123456789ABCDEF_0123456789ABCDEF,
                    beats: {32'h01234567, 32'h89ABCDEF,
                            32'h01234567, 32'h89ABCDEF}};
        vecs[1] = '{tag: 2'b10,
                    blk: 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0,
                    beats: {32'hDEADBEEF, 32'hCAFEF00D,
                            32'h12345678, 32'h9ABCDEF0}};
        vecs[2] = '{tag: 2'b11,
                    blk: 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A,
                    beats: {32'hFFFFFFFF, 32'h00000000,
                            32'hA5A5A5A5, 32'h5A5A5A5A}};

        dif.out_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(dif.out_valid), 64'(0));
        chk("rst_last", 64'(dif.out_last), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rd_en", 64'(dif.fifo_rd_en), 64'(0));
        chk("rst_entry_cnt", 64'(entry_cnt), 64'(0));
        chk("rst_tag", 64'(dif.out_tag), 64'(0));

        rstn = 1'b1;
        enable = 1'b1;
        dif.out_ready = 1'b1;
        step();

        // Table vectors, each with the fetch latency checked
        for (int k = 0; k < 3; k++) begin
            r0 = rd_seen;
            push(vecs[k].tag, vecs[k].blk);
            #1;
            chk("lat_rd_t0", 64'(dif.fifo_rd_en), 64'(1));
            chk("lat_valid_t0", 64'(dif.out_valid), 64'(0));
            step();
            chk("lat_valid_t1", 64'(dif.out_valid), 64'(0));
            chk("lat_busy_t1", 64'(busy), 64'(1));
            chk("lat_rd_t1", 64'(dif.fifo_rd_en), 64'(0));
            step();
            chk("lat_valid_t2", 64'(dif.out_valid), 64'(1));
            chk("lat_data_t2", 64'(dif.out_data),
                64'(vecs[k].beats[0]));
            drain(40);
            chk("vec_count", 64'(got.size()), 64'(4));
            for (int i = 0; i < got.size() && i < 4; i++)
                chk("vec_beat", 64'(got[i]),
                    64'({vecs[k].beats[i], vecs[k].tag, i == 3}));
            chk("vec_rd_once", 64'(rd_seen - r0), 64'(1));
            ecnt++;
            chk("vec_entry_cnt", 64'(entry_cnt), 64'(ecnt));
            got.delete();
            got_cyc.delete();
            exp.delete();
        end

        // Back-to-back entries with the sink always ready
        for (int k = 0; k < 3; k++)
            push(2'($urandom_range(0, 3)),
                 {$urandom(), $urandom(), $urandom(), $urandom()});
        drain(80);
        for (int k = 1; k < 3 && 4 * k < got_cyc.size(); k++)
            chk("b2b_period", 64'(got_cyc[4*k] - got_cyc[4*k-4]),
                64'(6));
        ecnt += 3;
        score("b2b");
        chk("b2b_entry_cnt", 64'(entry_cnt), 64'(ecnt));

        // Random back-pressure and enable
        for (int k = 0; k < 20; k++)
            push(2'($urandom_range(0, 3)),
                 {$urandom(), $urandom(), $urandom(), $urandom()});
        n = 0;
        while (got.size() < exp.size() && n < 3000) begin
            dif.out_ready = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        dif.out_ready = 1'b1;
        enable = 1'b1;
        drain(60);
        ecnt += 20;
        score("rand");
        chk("rand_entry_cnt", 64'(entry_cnt), 64'(ecnt));

        // Enable dropped mid-entry: entry finishes, no new fetch
        r0 = rd_seen;
        push(2'b10, {$urandom(), $urandom(), $urandom(), $urandom()});
        push(2'b01, {$urandom(), $urandom(), $urandom(), $urandom()});
        n = 0;
        while (got.size() < 2 && n < 20) begin
            step();
            n++;
        end
        enable = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 8; i++) step();
        chk("en_drop_rd", 64'(rd_seen - r0), 64'(1));
        chk("en_drop_beats", 64'(got.size()), 64'(4));
        chk("en_drop_busy", 64'(busy), 64'(0));
        chk("en_drop_fifo", 64'(dif.fifo_empty), 64'(0));
        enable = 1'b1;
        drain(40);
        ecnt += 2;
        score("en_drop");
        chk("en_drop_cnt", 64'(entry_cnt), 64'(ecnt));

        // Reset while beat 1 is on the bus
        push(2'b11, {$urandom(), $urandom(), $urandom(), $urandom()});
        n = 0;
        while (got.size() < 1 && n < 20) begin
            step();
            n++;
        end
        push(2'b01, {$urandom(), $urandom(), $urandom(), $urandom()});
        chk("mid_beat0", 64'(got.size() > 0 ? got[0] : '0),
            64'(exp[0]));
        rstn = 1'b0;
        r0 = rd_seen;
        step();
        chk("mid_rst_rd", 64'(rd_seen - r0), 64'(0));
        chk("mid_rst_valid", 64'(dif.out_valid), 64'(0));
        chk("mid_rst_last", 64'(dif.out_last), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_cnt", 64'(entry_cnt), 64'(0));
        rstn = 1'b1;
        got.delete();
        got_cyc.delete();
        for (int i = 0; i < NBEATS; i++) void'(exp.pop_front());
        ecnt = 0;
        drain(40);
        ecnt++;
        score("post_rst");
        chk("post_rst_cnt", 64'(entry_cnt), 64'(ecnt));

        // Counter wrap from 0xFFFF
        force dut.entry_cnt = 16'hFFFF;
        step();
        release dut.entry_cnt;
        step();
        chk("wrap_pre", 64'(entry_cnt), 64'(16'hFFFF));
        push(2'b00, {$urandom(), $urandom(), $urandom(), $urandom()});
        drain(40);
        ecnt = 0;
        chk("wrap_cnt", 64'(entry_cnt), 64'(ecnt));
        score("wrap");
        chk("tag_field", 64'(TAG_LSB), 64'(WIDTH - 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/output_drain_ctrl.md
OUTPUT_DRAIN_CTRL -- requirements
Module: output_drain_ctrl

Interface
REQ-001 Parameter WIDTH, default 130: output FIFO entry width; bits [127:0] are the AES block, bits [129:128] are the tag.
REQ-002 Parameter OUT_W, default 32: output beat width; WIDTH-2 SHALL be an exact multiple of OUT_W.
REQ-003 clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rstn  input  1: reset, synchronous and active-low.
REQ-005 enable  input  1: when high, draining of the FIFO is permitted.
REQ-006 fifo_empty  input  1: empty flag from the output FIFO.
REQ-007 fifo_dout  input  WIDTH: FIFO read data, valid on the cycle after fifo_rd_en.
REQ-008 fifo_rd_en  output  1: single-cycle FIFO read strobe.
REQ-009 out_valid  output  1: beat valid.
REQ-010 out_ready  input  1: downstream accepts the beat.
REQ-011 out_data  output  OUT_W: current beat.
REQ-012 out_tag  output  2: tag of the entry in flight, held for all of its beats.
REQ-013 out_last  output  1: marks the final beat of an entry.
REQ-014 busy  output  1: high in any state other than IDLE.
REQ-015 entry_cnt  output  16: count of fully transmitted entries.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and SEND.
REQ-017 IDLE: when enable=1 and fifo_empty=0, fifo_rd_en SHALL be high (combinational) that cycle, and the next state SHALL be FETCH; otherwise the FSM stays in IDLE.
REQ-018 fifo_rd_en SHALL be high only in IDLE under the REQ-017 condition: never in FETCH or SEND, never when fifo_empty=1.
REQ-019 FETCH: the block SHALL capture fifo_dout[127:0] into the shift register, capture [129:128] into the tag register, clear beat_cnt to 0, and go to SEND.
REQ-020 SEND: out_valid=1; out_data = block[beat_cnt*OUT_W +: OUT_W], least-significant beat first.
REQ-021 out_last SHALL be 1 when beat_cnt = NBEATS-1, where NBEATS = (WIDTH-2)/OUT_W = 4.
REQ-022 A handshake is out_valid && out_ready; out_data, out_tag and out_last SHALL stay stable until it occurs.
REQ-023 A handshake with out_last=0 SHALL increment beat_cnt.
REQ-024 A handshake with out_last=1 SHALL increment entry_cnt (mod 2^16, so 0xFFFF wraps to 0x0000) and return the FSM to IDLE.
REQ-025 Latency: fifo_empty falling at cycle t with enable=1 SHALL give fifo_rd_en at t and out_valid at t+2; with out_ready held high, the minimum period is 6 cycles per entry.
REQ-026 Deasserting enable during FETCH or SEND SHALL NOT abort the entry in flight; the entry completes and the FSM then idles.
REQ-027 out_ready high while out_valid=0 SHALL be ignored.
REQ-028 fifo_empty is not sampled outside IDLE.

Reset
REQ-029 On rstn=0 at a clock edge: state=IDLE, beat_cnt=0, shift register and tag=0, entry_cnt=0, out_valid=0, out_last=0, busy=0, fifo_rd_en=0.
REQ-030 Reset mid-operation SHALL discard the entry in flight without completing it and SHALL NOT raise fifo_rd_en in the reset cycle.

Structure
REQ-031 The state enum, NBEATS and the tag field positions SHALL live in the shared system package used with sysdef.svh, so both FIFO users and this block see one definition.
REQ-032 No sub-module; the FIFO is instantiated by the parent and connected through the fifo_* ports.

Verification
REQ-033 Reset, then one entry with tag 2'b01 and data 0x0123...CDEF (128-bit), out_ready=1: beats 0x89ABCDEF, 0x01234567, ... LSW first; out_last on beat 4; entry_cnt=1; fifo_rd_en high for exactly 1 cycle.
REQ-034 Back-to-back 3 entries, out_ready=1: 12 beats in order, each entry starting 6 cycles after the previous one; entry_cnt=3.
REQ-035 out_ready toggled 1,0,0,1,... on a random pattern: no beat lost or duplicated, and out_data/out_tag stable while stalled.
REQ-036 enable dropped on beat 2 of an entry: the entry completes, no further fifo_rd_en, busy=0 afterwards.
REQ-037 rstn=0 during SEND beat 1: outputs return to reset values next cycle; the next entry transmits from beat 0.
REQ-038 Preload entry_cnt to 0xFFFF via 65535 entries (or force): one more entry gives entry_cnt=0x0000.
